// File: rtl/gram_accumulator.sv
// Streaming Gram-matrix engine: accumulates XtX (upper triangle, mirrored) and XtY over N_SAMPLES rows.
// Optional implicit bias column 0 is enabled by defining GRAM_ACCUMULATOR_BIAS_COL_EN.
module gram_accumulator #(
  parameter int N_SAMPLES = 200,
  parameter int N_FEAT    = 10,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 0,
  parameter int ACC_W     = 48,
  parameter int X_AW      = 12,
  parameter int Y_AW      = 8,
  parameter int R_AW      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [X_AW-1:0]          xa_addr,
  input  logic signed [DATA_W-1:0] xa_data,
  output logic [X_AW-1:0]          xb_addr,
  input  logic signed [DATA_W-1:0] xb_data,
  output logic [Y_AW-1:0]          y_addr,
  input  logic signed [DATA_W-1:0] y_data,
  output logic                     res_we,
  output logic [R_AW-1:0]          res_addr,
  output logic signed [ACC_W-1:0]  res_data
);

`ifdef GRAM_ACCUMULATOR_BIAS_COL_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  localparam int C = BIAS_EN ? N_FEAT + 1 : N_FEAT;
  localparam logic signed [DATA_W-1:0] BIAS_VAL = DATA_W'(1 << FRAC_BITS);
  localparam int PW = 2 * DATA_W;

  typedef enum logic [2:0] {IDLE, SETUP, STREAM, DRAIN, WRITE, MIRROR, DONE} state_t;

  state_t            state;
  logic [R_AW-1:0]   r;
  logic [R_AW-1:0]   c;
  logic              is_y;
  logic [Y_AW-1:0]   k;
  logic [X_AW-1:0]   base;
  logic              drain_cnt;

  logic                    vld_p1;
  logic                    vld_p2;
  logic signed [PW-1:0]    prod_p2;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [DATA_W-1:0] a_op;
  logic signed [DATA_W-1:0] b_op;

  logic            last_job;
  logic [R_AW-1:0] nr;
  logic [R_AW-1:0] nc;
  logic            ny;
  logic [X_AW-1:0] base_nxt;

  // Physical X address of logical column col for the row starting at row_base.
  function automatic logic [X_AW-1:0] col_addr(input logic [X_AW-1:0] row_base,
                                               input logic [R_AW-1:0] col);
    if (BIAS_EN && col == '0) return '0;
    if (BIAS_EN) return row_base + X_AW'(col) - X_AW'(1);
    return row_base + X_AW'(col);
  endfunction

  function automatic logic [R_AW-1:0] tri_addr(input logic [R_AW-1:0] row,
                                               input logic [R_AW-1:0] col);
    return row * R_AW'(C) + col;
  endfunction

  // Product brought to accumulator width; truncates when ACC_W is narrower.
  function automatic logic signed [ACC_W-1:0] fit_prod(input logic signed [PW-1:0] p);
    return ACC_W'(p);
  endfunction

  function automatic logic signed [ACC_W-1:0] wrap_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W-1:0] b);
    return a + b;
  endfunction

  assign base_nxt = base + X_AW'(N_FEAT);

  // Next job in upper-triangle order, XtY[r] closing each row.
  always_comb begin
    last_job = 1'b0;
    nr       = r;
    nc       = c;
    ny       = is_y;
    if (is_y) begin
      if (r == R_AW'(C - 1)) begin
        last_job = 1'b1;
      end else begin
        nr = r + R_AW'(1);
        nc = r + R_AW'(1);
        ny = 1'b0;
      end
    end else if (c == R_AW'(C - 1)) begin
      ny = 1'b1;
    end else begin
      nc = c + R_AW'(1);
    end
  end

  // p1: memory data valid, operand select (r/c stay fixed until WRITE)
  always_comb begin
    a_op = (BIAS_EN && r == '0) ? BIAS_VAL : xa_data;
    if (is_y)                    b_op = y_data;
    else if (BIAS_EN && c == '0) b_op = BIAS_VAL;
    else                         b_op = xb_data;
  end

  assign acc_next = vld_p2 ? wrap_add(acc, fit_prod(prod_p2)) : acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= (state == STREAM);
      vld_p2 <= vld_p1;
    end
  end

  // p2: registered product
  always_ff @(posedge clk) begin
    prod_p2 <= PW'(a_op) * PW'(b_op);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               acc <= '0;
    else if (state == SETUP) acc <= '0;
    else                     acc <= acc_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      xa_addr   <= '0;
      xb_addr   <= '0;
      y_addr    <= '0;
      res_we    <= 1'b0;
      res_addr  <= '0;
      res_data  <= '0;
      r         <= '0;
      c         <= '0;
      is_y      <= 1'b0;
      k         <= '0;
      base      <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          res_we <= 1'b0;
          done   <= 1'b0;
          if (start) begin
            state <= SETUP;
            busy  <= 1'b1;
            r     <= '0;
            c     <= '0;
            is_y  <= 1'b0;
          end
        end
        SETUP: begin
          k       <= '0;
          base    <= '0;
          xa_addr <= col_addr('0, r);
          if (is_y) y_addr  <= '0;
          else      xb_addr <= col_addr('0, c);
          state   <= STREAM;
        end
        STREAM: begin
          if (k == Y_AW'(N_SAMPLES - 1)) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            k       <= k + Y_AW'(1);
            base    <= base_nxt;
            xa_addr <= col_addr(base_nxt, r);
            if (is_y) y_addr  <= k + Y_AW'(1);
            else      xb_addr <= col_addr(base_nxt, c);
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state    <= WRITE;
            res_we   <= 1'b1;
            res_addr <= is_y ? R_AW'(C * C) + r : tri_addr(r, c);
            res_data <= acc_next;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        WRITE, MIRROR: begin
          if (state == WRITE && !is_y && r != c) begin
            state    <= MIRROR;
            res_addr <= tri_addr(c, r);
          end else begin
            res_we <= 1'b0;
            r      <= nr;
            c      <= nc;
            is_y   <= ny;
            if (last_job) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= SETUP;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gram_accumulator.sv
// Directed bench for gram_accumulator with N_SAMPLES=4, N_FEAT=1, FRAC_BITS=0 (plus an ACC_W=16 instance).
module tb_gram_accumulator;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic start16;
  always #5 clk = ~clk;

  logic                busy, done, res_we;
  logic [11:0]         xa_addr, xb_addr;
  logic [7:0]          y_addr, res_addr;
  logic signed [15:0]  xa_data, xb_data, y_data;
  logic signed [47:0]  res_data;

  logic                busy16, done16, res16_we;
  logic [11:0]         xa16_addr, xb16_addr;
  logic [7:0]          y16_addr, res16_addr;
  logic signed [15:0]  xa16_data, xb16_data, y16_data;
  logic signed [15:0]  res16_data;

  gram_accumulator #(.N_SAMPLES(NS), .N_FEAT(1), .DATA_W(16), .FRAC_BITS(0), .ACC_W(48),
                     .X_AW(12), .Y_AW(8), .R_AW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .xa_addr(xa_addr), .xa_data(xa_data), .xb_addr(xb_addr), .xb_data(xb_data),
    .y_addr(y_addr), .y_data(y_data),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data));

  gram_accumulator #(.N_SAMPLES(NS), .N_FEAT(1), .DATA_W(16), .FRAC_BITS(0), .ACC_W(16),
                     .X_AW(12), .Y_AW(8), .R_AW(8)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .busy(busy16), .done(done16),
    .xa_addr(xa16_addr), .xa_data(xa16_data), .xb_addr(xb16_addr), .xb_data(xb16_data),
    .y_addr(y16_addr), .y_data(y16_data),
    .res_we(res16_we), .res_addr(res16_addr), .res_data(res16_data));

  logic signed [15:0] xmem [4];
  logic signed [15:0] ymem [4];

  always @(posedge clk) begin
    xa_data   <= xmem[xa_addr[1:0]];
    xb_data   <= xmem[xb_addr[1:0]];
    y_data    <= ymem[y_addr[1:0]];
    xa16_data <= 16'sd32767;
    xb16_data <= 16'sd32767;
    y16_data  <= 16'sd32767;
  end

  int                 wr_n = 0;
  int                 busy_cyc = 0;
  logic [7:0]         wr_addr [512];
  logic signed [47:0] wr_data [512];

  always @(negedge clk) begin
    if (res_we) begin
      if (wr_n < 512) begin
        wr_addr[wr_n] = res_addr;
        wr_data[wr_n] = res_data;
      end
      wr_n = wr_n + 1;
    end
    if (busy) busy_cyc = busy_cyc + 1;
  end

  typedef struct {
    logic [0:3][15:0] x;
    logic [0:3][15:0] y;
    int               nw;
    logic [0:5][7:0]  a;
    logic [0:5][47:0] d;
    int               bcyc;
  } vec_t;

  vec_t v [3];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_done(output logic seen);
    seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_vec(input int i);
    for (int j = 0; j < 4; j++) begin
      xmem[j] = v[i].x[j];
      ymem[j] = v[i].y[j];
    end
  endtask

  task automatic run_vec(input int i, input string tag);
    int   w0, b0;
    logic seen;
    load_vec(i);
    @(negedge clk);
    w0 = wr_n;
    b0 = busy_cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(seen);
    #1;
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(busy_cyc - b0), 64'(v[i].bcyc));
    chk({tag, "_nwrites"}, 64'(wr_n - w0), 64'(v[i].nw));
    for (int j = 0; j < v[i].nw; j++) begin
      chk($sformatf("%s_addr%0d", tag, j), 64'(wr_addr[w0 + j]), 64'(v[i].a[j]));
      chk($sformatf("%s_data%0d", tag, j), wr_data[w0 + j], $signed(v[i].d[j]));
    end
    @(negedge clk);
    chk({tag, "_done_pulse_len"}, 64'(done), 64'd0);
  endtask

  initial begin
    int   w0, w1, b0;
    logic seen;
    logic signed [15:0] got16;
    logic got16_seen;

`ifdef GRAM_ACCUMULATOR_BIAS_COL_EN
    v[0] = '{x: {16'sd1, 16'sd2, 16'sd3, 16'sd4}, y: {16'sd2, 16'sd4, 16'sd6, 16'sd8}, nw: 6,
             a: {8'd0, 8'd1, 8'd2, 8'd4, 8'd3, 8'd5},
             d: {48'sd4, 48'sd10, 48'sd10, 48'sd20, 48'sd30, 48'sd60}, bcyc: 41};
    v[1] = '{x: {-16'sd1, -16'sd2, -16'sd3, -16'sd4}, y: {16'sd2, 16'sd4, 16'sd6, 16'sd8}, nw: 6,
             a: {8'd0, 8'd1, 8'd2, 8'd4, 8'd3, 8'd5},
             d: {48'sd4, -48'sd10, -48'sd10, 48'sd20, 48'sd30, -48'sd60}, bcyc: 41};
    v[2] = '{x: {16'sd5, -16'sd3, 16'sd0, 16'sd7}, y: {16'sd1, 16'sd1, -16'sd2, 16'sd3}, nw: 6,
             a: {8'd0, 8'd1, 8'd2, 8'd4, 8'd3, 8'd5},
             d: {48'sd4, 48'sd9, 48'sd9, 48'sd3, 48'sd83, 48'sd23}, bcyc: 41};
`else
    v[0] = '{x: {16'sd1, 16'sd2, 16'sd3, 16'sd4}, y: {16'sd2, 16'sd4, 16'sd6, 16'sd8}, nw: 2,
             a: {8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0},
             d: {48'sd30, 48'sd60, 48'sd0, 48'sd0, 48'sd0, 48'sd0}, bcyc: 16};
    v[1] = '{x: {-16'sd1, -16'sd2, -16'sd3, -16'sd4}, y: {16'sd2, 16'sd4, 16'sd6, 16'sd8}, nw: 2,
             a: {8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0},
             d: {48'sd30, -48'sd60, 48'sd0, 48'sd0, 48'sd0, 48'sd0}, bcyc: 16};
    v[2] = '{x: {16'sd5, -16'sd3, 16'sd0, 16'sd7}, y: {16'sd1, 16'sd1, -16'sd2, 16'sd3}, nw: 2,
             a: {8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0},
             d: {48'sd83, 48'sd23, 48'sd0, 48'sd0, 48'sd0, 48'sd0}, bcyc: 16};
`endif

    reset   = 1'b1;
    start   = 1'b0;
    start16 = 1'b0;
    load_vec(0);
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_res_we", 64'(res_we), 64'd0);
    chk("rst_res_addr", 64'(res_addr), 64'd0);
    chk("rst_res_data", res_data, 64'sd0);
    chk("rst_xa_addr", 64'(xa_addr), 64'd0);
    chk("rst_y_addr", 64'(y_addr), 64'd0);
    chk("rst16_res_we", 64'(res16_we), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) run_vec(i, $sformatf("vec%0d", i));

    // Reset during STREAM of the second job.
    load_vec(0);
    w0 = wr_n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 50 && wr_n == w0; n++) @(negedge clk);
    chk("abort_first_write_seen", 64'(wr_n - w0 > 0), 64'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_res_we", 64'(res_we), 64'd0);
    chk("abort_res_data", res_data, 64'sd0);
    chk("abort_xa_addr", 64'(xa_addr), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    w1 = wr_n;
    repeat (20) @(negedge clk);
    #1;
    chk("abort_no_writes", 64'(wr_n - w1), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);
    run_vec(0, "after_abort");

    // start held high across a whole run.
    load_vec(0);
    @(negedge clk);
    w0 = wr_n;
    b0 = busy_cyc;
    start = 1'b1;
    wait_done(seen);
    #1;
    chk("hold_done_seen", 64'(seen), 64'd1);
    chk("hold_single_run_writes", 64'(wr_n - w0), 64'(v[0].nw));
    chk("hold_single_run_busy", 64'(busy_cyc - b0), 64'(v[0].bcyc));
    @(negedge clk);
    chk("hold_idle_gap", 64'(busy), 64'd0);
    @(negedge clk);
    chk("hold_restart", 64'(busy), 64'd1);
    start = 1'b0;
    w1 = wr_n;
    wait_done(seen);
    #1;
    chk("hold_second_done", 64'(seen), 64'd1);
    chk("hold_second_writes", 64'(wr_n - w1), 64'(v[0].nw));
    chk("hold_second_last_data", wr_data[w1 + v[0].nw - 1], $signed(v[0].d[v[0].nw - 1]));

    // ACC_W=16 wrap of XtY[0].
    got16 = '0;
    got16_seen = 1'b0;
    @(negedge clk);
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
`ifdef GRAM_ACCUMULATOR_BIAS_COL_EN
      if (res16_we && res16_addr == 8'd4) begin
`else
      if (res16_we && res16_addr == 8'd1) begin
`endif
        got16 = res16_data;
        got16_seen = 1'b1;
      end
      if (done16) begin
        seen = 1'b1;
        break;
      end
    end
    chk("acc16_done_seen", 64'(seen), 64'd1);
    chk("acc16_xty0_written", 64'(got16_seen), 64'd1);
`ifdef GRAM_ACCUMULATOR_BIAS_COL_EN
    chk("acc16_xty0", got16, -64'sd4);
`else
    chk("acc16_xty0", got16, 64'sd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
